// File: rtl/dmem_responder.sv
// Word-addressed data-memory responder with byte-enabled stores and range/alignment error reporting.
// Latency: request accept to resp_valid is LATENCY+1 cycles; one request in flight at a time.
// Backpressure: req_ready is low outside IDLE; the response is held stable in RESP until resp_ready.
module dmem_responder #(
  parameter int MEM_DEPTH = 1024,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int          IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [29:0] N_WORD = 30'(MEM_DEPTH);
  localparam logic [3:0]  LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;

  // Captured request, valid from the accept edge until the response is formed
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [MEM_DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        leave_resp;

  // Request seen by the response logic: live inputs when entering RESP
  // straight from IDLE (zero wait states), captured copy otherwise.
  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [3:0]  cur_be;
  logic [29:0] cur_word;
  logic [IDX_W-1:0] cur_idx;
  logic        cur_err;
  logic        commit_wr;

  // State and wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state, handshake outputs and transition strobes
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    accept     = 1'b0;
    enter_resp = 1'b0;
    leave_resp = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = LAT_M1;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nxt  = IDLE;
          leave_resp = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Select the request being answered and decode its address
  always_comb begin
    if (state == IDLE) begin
      cur_we    = req_we;
      cur_addr  = req_addr;
      cur_wdata = req_wdata;
      cur_be    = req_be;
    end else begin
      cur_we    = we_q;
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_be    = be_q;
    end
    cur_word  = cur_addr[31:2];
    cur_idx   = cur_word[IDX_W-1:0];
    // No wrap: any word index at or above the depth is an error
    cur_err   = (cur_addr[1:0] != 2'b00) || (cur_word >= N_WORD);
    // Reset term keeps a zero-latency store from landing while reset is held
    commit_wr = enter_resp && cur_we && !cur_err && reset;
  end

  // Capture the request on accept
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else if (accept) begin
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      be_q    <= req_be;
    end
  end

  // Form the response when entering RESP, clear it on the handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= cur_err;
      resp_rdata <= (!cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
    end else if (leave_resp) begin
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end
  end

  // Byte-lane store commit; the array itself is never reset
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_be[i]) begin
          mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
// Expected responses are queued at issue time and checked by per-instance monitors.
// Timing and handshake checks are made directly by the stimulus process.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Instance A (LATENCY=2)
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [3:0]  a_req_be;
  logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
  logic [31:0] a_resp_rdata;

  // Instance B (LATENCY=0), response side always ready
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic [3:0]  b_req_be;
  logic        b_resp_valid, b_resp_err, b_busy;
  logic        b_resp_ready;
  logic [31:0] b_resp_rdata;
  assign b_resp_ready = 1'b1;

  dmem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT_A)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err), .busy(a_busy)
  );

  dmem_responder #(.MEM_DEPTH(DEPTH), .LATENCY(LAT_B)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  // Directed vectors for the zero-latency back-to-back burst
  logic        bv_we    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] bv_wdata [4] = '{32'hCAFEF00D, 32'h0, 32'h000000AB, 32'h0};
  logic [3:0]  bv_be    [4] = '{4'hF, 4'hF, 4'b0001, 4'hF};
  logic [31:0] bv_exp   [4] = '{32'h0, 32'hCAFEF00D, 32'h0, 32'hCAFEF0AB};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor A: compare every accepted response against the queue head
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (a_resp_valid && a_resp_ready) begin
      if (qa.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL a_resp_unexpected actual=%h required=none", a_resp_rdata);
      end else begin
        e = qa.pop_front();
        chk("a_resp_rdata", a_resp_rdata, e.rdata);
        chk("a_resp_err", {31'd0, a_resp_err}, {31'd0, e.err});
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin : mon_b
    exp_t e;
    if (b_resp_valid && b_resp_ready) begin
      if (qb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL b_resp_unexpected actual=%h required=none", b_resp_rdata);
      end else begin
        e = qb.pop_front();
        chk("b_resp_rdata", b_resp_rdata, e.rdata);
        chk("b_resp_err", {31'd0, b_resp_err}, {31'd0, e.err});
      end
    end
  end

  // Issue one request on A from a negedge; returns at the negedge where resp_valid is first seen
  task automatic a_req(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       input logic [31:0] exp_rd, input logic exp_err);
    int n;
    int lat;
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_req_be    = be;
    n = 0;
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!a_req_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout actual=0 required=1", tag);
      a_req_valid = 1'b0;
      return;
    end
    qa.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    a_req_valid = 1'b0;
    lat = 1;
    while (!a_resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(LAT_A + 1));
  endtask

  initial begin
    if (LAT_A > 15 || LAT_B > 15) begin
      $display("FAIL latency_param actual=%0d/%0d required=<=15", LAT_A, LAT_B);
      $fatal(1, "LATENCY out of range");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t_prev;
    reset        = 1'b0;
    a_req_valid  = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_req_be = '0;
    a_resp_ready = 1'b1;
    b_req_valid  = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_req_be = '0;
    t_prev       = 0;

    // Reset values
    #1;
    chk("rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("rst_resp_rdata", a_resp_rdata, 32'd0);
    chk("rst_resp_err", {31'd0, a_resp_err}, 32'd0);
    chk("rst_busy", {31'd0, a_busy}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, a_req_ready}, 32'd1);

    // Full-word store then load
    a_req("st_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    a_req("ld_10", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Byte-enable merge
    a_req("st_20", 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0);
    a_req("st_20_be", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    a_req("ld_20", 1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB33DD, 1'b0);

    // Errors: misaligned load, out-of-range store must not alias onto word 0
    a_req("st_00", 1'b1, 32'h0, 32'h01020304, 4'hF, 32'h0, 1'b0);
    a_req("ld_13", 1'b0, 32'h13, 32'h0, 4'hF, 32'h0, 1'b1);
    a_req("st_1000", 1'b1, 32'h1000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    a_req("ld_00", 1'b0, 32'h0, 32'h0, 4'hF, 32'h01020304, 1'b0);

    // Response backpressure
    @(posedge clk);
    #1 a_resp_ready = 1'b0;
    @(negedge clk);
    a_req("ld_10_bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_resp_valid", {31'd0, a_resp_valid}, 32'd1);
      chk("bp_resp_rdata", a_resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready", {31'd0, a_req_ready}, 32'd0);
      if (k == 1) begin
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h10;
        a_req_wdata = 32'h0; a_req_be = 4'hF;
      end else begin
        a_req_valid = 1'b0;
      end
      @(negedge clk);
    end
    a_req_valid = 1'b0;
    @(posedge clk);
    #1 a_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("bp_idle_resp_rdata", a_resp_rdata, 32'd0);
    chk("bp_idle_req_ready", {31'd0, a_req_ready}, 32'd1);
    a_req("ld_10_after_bp", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

    // Reset mid-flight: uncommitted store must not land
    a_req("st_40", 1'b1, 32'h40, 32'h12345678, 4'hF, 32'h0, 1'b0);
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'h40;
    a_req_wdata = 32'h00000055; a_req_be = 4'hF;
    n = 0;
    while (!a_req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("mid_accept_ready", {31'd0, a_req_ready}, 32'd1);
    @(negedge clk);
    a_req_valid = 1'b0;
    chk("mid_busy_wait", {31'd0, a_busy}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, a_busy}, 32'd0);
    chk("mid_rst_resp_valid", {31'd0, a_resp_valid}, 32'd0);
    chk("mid_rst_resp_rdata", a_resp_rdata, 32'd0);
    chk("mid_rst_resp_err", {31'd0, a_resp_err}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rel_req_ready", {31'd0, a_req_ready}, 32'd1);
    a_req("ld_40", 1'b0, 32'h40, 32'h0, 4'hF, 32'h12345678, 1'b0);

    // Zero latency, back-to-back with resp_ready tied high
    @(negedge clk);
    b_req_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b_req_we    = bv_we[k];
      b_req_addr  = 32'h8;
      b_req_wdata = bv_wdata[k];
      b_req_be    = bv_be[k];
      n = 0;
      while (!b_req_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      if (!b_req_ready) begin
        checks++;
        failures++;
        $display("FAIL b_accept_timeout actual=0 required=1");
        break;
      end
      if (k > 0) chk("b_accept_spacing", 32'(cyc - t_prev), 32'd2);
      t_prev = cyc;
      qb.push_back('{rdata: bv_exp[k], err: 1'b0});
      @(negedge clk);
      chk("b_latency", {31'd0, b_resp_valid}, 32'd1);
    end
    b_req_valid = 1'b0;

    repeat (4) @(negedge clk);
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
